// File: rtl/vram_slot_arbiter.sv
// Time-slot arbiter sharing the single-port display RAM between the 6502 bus
// and the video character fetch; phase 0 of each slot period belongs to video.
module vram_slot_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int SLOT_LEN = 6
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_busy,
    output logic              cpu_ack,
    output logic [7:0]        cpu_rdata,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic [7:0]        vid_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    output logic [2:0]        slot_phase,
    output logic [1:0]        overrun
);

    localparam logic [2:0] LAST_PHASE = 3'(SLOT_LEN - 1);

    typedef enum logic [1:0] {CPU_IDLE, CPU_PEND, CPU_RD, CPU_ACK} cpu_state_t;
    typedef enum logic [1:0] {TAG_NONE, TAG_CPU, TAG_VID} tag_t;

    cpu_state_t        state_q, state_d;
    tag_t              tag_p1, tag_p2;
    logic              cpu_pend, vid_pend;
    logic              cpu_we_q;
    logic [ADDR_W-1:0] cpu_addr_q, vid_addr_q, last_addr_q;
    logic [7:0]        cpu_wdata_q;
    logic              issue_vid, issue_cpu;

    // The CPU pending bit is the PEND state itself.
    assign cpu_pend  = (state_q == CPU_PEND);
    assign issue_vid = vid_pend && (slot_phase == 3'd0);
    assign issue_cpu = cpu_pend && !issue_vid;
    assign cpu_busy  = (state_q != CPU_IDLE);
    assign cpu_ack   = (state_q == CPU_ACK);
    assign vid_ack   = (tag_p2 == TAG_VID);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            slot_phase <= 3'd0;
        end else if (slot_phase == LAST_PHASE) begin
            slot_phase <= 3'd0;
        end else begin
            slot_phase <= slot_phase + 3'd1;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q <= CPU_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            CPU_IDLE: if (cpu_req) state_d = CPU_PEND;
            CPU_PEND: if (issue_cpu) state_d = cpu_we_q ? CPU_ACK : CPU_RD;
            CPU_RD:   state_d = CPU_ACK;
            CPU_ACK:  state_d = CPU_IDLE;
            default:  state_d = CPU_IDLE;
        endcase
    end

    // Issue stage: at most one RAM access per cycle.
    always_comb begin
        ram_addr  = last_addr_q;
        ram_we    = 1'b0;
        ram_wdata = 8'd0;
        if (issue_vid) begin
            ram_addr = vid_addr_q;
        end else if (issue_cpu) begin
            ram_addr = cpu_addr_q;
            ram_we   = cpu_we_q;
            if (cpu_we_q) ram_wdata = cpu_wdata_q;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cpu_we_q    <= 1'b0;
            cpu_addr_q  <= '0;
            cpu_wdata_q <= 8'd0;
            vid_pend    <= 1'b0;
            vid_addr_q  <= '0;
            last_addr_q <= '0;
            overrun     <= 2'b00;
        end else begin
            if (cpu_req && !cpu_busy) begin
                cpu_we_q    <= cpu_we;
                cpu_addr_q  <= cpu_addr;
                cpu_wdata_q <= cpu_wdata;
            end
            // A new strobe wins over clearing, so a strobe in the issue cycle re-arms.
            if (vid_req) begin
                vid_pend   <= 1'b1;
                vid_addr_q <= vid_addr;
            end else if (issue_vid) begin
                vid_pend <= 1'b0;
            end
            last_addr_q <= ram_addr;
            if (cpu_req && cpu_busy) overrun[0] <= 1'b1;
            if (vid_req && vid_pend && !issue_vid) overrun[1] <= 1'b1;
        end
    end

    // Stage 1: RAM data valid, route it by tag; stage 2: ack.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            tag_p1    <= TAG_NONE;
            tag_p2    <= TAG_NONE;
            cpu_rdata <= 8'd0;
            vid_data  <= 8'd0;
        end else begin
            if (issue_vid) begin
                tag_p1 <= TAG_VID;
            end else if (issue_cpu && !cpu_we_q) begin
                tag_p1 <= TAG_CPU;
            end else begin
                tag_p1 <= TAG_NONE;
            end
            tag_p2 <= tag_p1;
            if (tag_p1 == TAG_CPU) cpu_rdata <= ram_rdata;
            if (tag_p1 == TAG_VID) vid_data  <= ram_rdata;
        end
    end

endmodule
